// File: rtl/sys_ctrl.sv
// sys_ctrl: machine-mode SYSTEM-instruction controller at the decode/execute boundary.
// Executes CSR read-modify-write ops, ECALL/EBREAK traps, MRET and WFI, takes the
// external interrupt, and issues PC redirects to fetch. Holds mstatus, mie, mip,
// mtvec, mscratch, mepc and mcause.
// Ports:
//   CLK, RSTn             clock, asynchronous active-low reset
//   I_VALID/I_READY       instruction handshake (SYSTEM opcode only)
//   I_INSTR, I_PC         instruction word and its PC
//   I_RS1_DATA            rs1 register value
//   IRQ_EXT               level external interrupt
//   O_RD_WE/ADDR/DATA     register-file write of the old CSR value (1-cycle pulse)
//   O_REDIRECT/_PC        fetch restart pulse and target
//   O_BUSY                controller not idle
module sys_ctrl #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        I_VALID,
  output logic        I_READY,
  input  logic [31:0] I_INSTR,
  input  logic [31:0] I_PC,
  input  logic [31:0] I_RS1_DATA,
  input  logic        IRQ_EXT,
  output logic        O_RD_WE,
  output logic [4:0]  O_RD_ADDR,
  output logic [31:0] O_RD_DATA,
  output logic        O_REDIRECT,
  output logic [31:0] O_REDIRECT_PC,
  output logic        O_BUSY
);

  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;
  localparam logic [31:0] INSTR_MRET   = 32'h3020_0073;
  localparam logic [31:0] INSTR_WFI    = 32'h1050_0073;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_TRAP, S_WFI} state_t;
  typedef enum logic [2:0] {K_CSR, K_ECALL, K_EBREAK, K_MRET, K_WFI, K_ILL} kind_t;

  state_t      state_q, state_d;
  kind_t       kind_q, kind_d;
  logic        mstatus_mie_q, mstatus_mie_d;
  logic        mstatus_mpie_q, mstatus_mpie_d;
  logic        mie_meie_q, mie_meie_d;
  logic        mip_meip_q;
  logic [31:0] mtvec_q, mtvec_d;
  logic [31:0] mscratch_q, mscratch_d;
  logic [31:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] pc_q, pc_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic        csr_we_q, csr_we_d;
  logic [31:0] csr_wval_q, csr_wval_d;
  logic        rd_we_q, rd_we_d;
  logic [4:0]  rd_addr_q, rd_addr_d;
  logic [31:0] rd_data_q, rd_data_d;
  logic        redir_q, redir_d;
  logic [31:0] redir_pc_q, redir_pc_d;

  // Decode of the presented instruction.
  logic [2:0]  dec_f3;
  logic [11:0] dec_csr;
  logic [4:0]  dec_rs1, dec_rd;
  logic [31:0] dec_src, dec_old, dec_wval;
  logic        dec_known, dec_wr;
  kind_t       dec_kind;
  logic        irq_take, accept;

  always_comb begin
    dec_f3    = I_INSTR[14:12];
    dec_csr   = I_INSTR[31:20];
    dec_rs1   = I_INSTR[19:15];
    dec_rd    = I_INSTR[11:7];
    dec_src   = dec_f3[2] ? {27'd0, dec_rs1} : I_RS1_DATA;
    dec_known = 1'b1;
    dec_old   = '0;
    case (dec_csr)
      CSR_MSTATUS:  dec_old = {19'd0, 2'b11, 3'd0, mstatus_mpie_q, 3'd0, mstatus_mie_q, 3'd0};
      CSR_MIE:      dec_old = {20'd0, mie_meie_q, 11'd0};
      CSR_MTVEC:    dec_old = mtvec_q;
      CSR_MSCRATCH: dec_old = mscratch_q;
      CSR_MEPC:     dec_old = mepc_q;
      CSR_MCAUSE:   dec_old = mcause_q;
      CSR_MIP:      dec_old = {20'd0, mip_meip_q, 11'd0};
      default:      dec_known = 1'b0;
    endcase
    // Set/clear with rs1 field zero are pure reads.
    dec_wr = (dec_f3[1:0] == 2'b01) || (dec_rs1 != 5'd0);
    case (dec_f3[1:0])
      2'b01:   dec_wval = dec_src;
      2'b10:   dec_wval = dec_old | dec_src;
      default: dec_wval = dec_old & ~dec_src;
    endcase
    if (I_INSTR == INSTR_ECALL)       dec_kind = K_ECALL;
    else if (I_INSTR == INSTR_EBREAK) dec_kind = K_EBREAK;
    else if (I_INSTR == INSTR_MRET)   dec_kind = K_MRET;
    else if (I_INSTR == INSTR_WFI)    dec_kind = K_WFI;
    else if (I_INSTR[6:0] != 7'b1110011 || dec_f3[1:0] == 2'b00 || !dec_known ||
             (dec_csr == CSR_MIP && dec_wr))
      dec_kind = K_ILL;
    else
      dec_kind = K_CSR;
  end

  assign irq_take = IRQ_EXT && mstatus_mie_q && mie_meie_q && I_VALID;
  assign I_READY  = (state_q == S_IDLE) && !irq_take;
  assign accept   = I_VALID && I_READY;

  // Result outputs are registered at accept so they pulse during EXEC; the CSR
  // side effects are applied at the end of EXEC from the captured operands.
  always_comb begin
    state_d        = state_q;
    kind_d         = kind_q;
    mstatus_mie_d  = mstatus_mie_q;
    mstatus_mpie_d = mstatus_mpie_q;
    mie_meie_d     = mie_meie_q;
    mtvec_d        = mtvec_q;
    mscratch_d     = mscratch_q;
    mepc_d         = mepc_q;
    mcause_d       = mcause_q;
    pc_d           = pc_q;
    csr_addr_d     = csr_addr_q;
    csr_we_d       = csr_we_q;
    csr_wval_d     = csr_wval_q;
    rd_we_d        = 1'b0;
    rd_addr_d      = rd_addr_q;
    rd_data_d      = rd_data_q;
    redir_d        = 1'b0;
    redir_pc_d     = redir_pc_q;
    case (state_q)
      S_IDLE: begin
        if (irq_take) begin
          mepc_d     = {I_PC[31:2], 2'b00};
          mcause_d   = 32'h8000_000B;
          redir_d    = 1'b1;
          redir_pc_d = mtvec_q;
          state_d    = S_TRAP;
        end else if (accept) begin
          kind_d     = dec_kind;
          pc_d       = I_PC;
          csr_addr_d = dec_csr;
          csr_we_d   = dec_wr;
          csr_wval_d = dec_wval;
          if (dec_kind == K_CSR) begin
            rd_we_d   = (dec_rd != 5'd0);
            rd_addr_d = dec_rd;
            rd_data_d = dec_old;
          end
          if (dec_kind == K_MRET) begin
            redir_d    = 1'b1;
            redir_pc_d = mepc_q;
          end
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (kind_q)
          K_CSR: begin
            if (csr_we_q) begin
              case (csr_addr_q)
                CSR_MSTATUS: begin
                  mstatus_mie_d  = csr_wval_q[3];
                  mstatus_mpie_d = csr_wval_q[7];
                end
                CSR_MIE:      mie_meie_d = csr_wval_q[11];
                CSR_MTVEC:    mtvec_d    = {csr_wval_q[31:2], 2'b00};
                CSR_MSCRATCH: mscratch_d = csr_wval_q;
                CSR_MEPC:     mepc_d     = {csr_wval_q[31:2], 2'b00};
                CSR_MCAUSE:   mcause_d   = csr_wval_q;
                default: ;
              endcase
            end
          end
          K_MRET: begin
            mstatus_mie_d  = mstatus_mpie_q;
            mstatus_mpie_d = 1'b1;
          end
          K_WFI: state_d = S_WFI;
          default: begin
            mepc_d     = {pc_q[31:2], 2'b00};
            mcause_d   = (kind_q == K_ECALL)  ? 32'd11 :
                         (kind_q == K_EBREAK) ? 32'd3  : 32'd2;
            redir_d    = 1'b1;
            redir_pc_d = mtvec_q;
            state_d    = S_TRAP;
          end
        endcase
      end
      S_TRAP: begin
        mstatus_mpie_d = mstatus_mie_q;
        mstatus_mie_d  = 1'b0;
        state_d        = S_IDLE;
      end
      S_WFI: begin
        if (IRQ_EXT && mie_meie_q) begin
          redir_d    = 1'b1;
          redir_pc_d = pc_q + 32'd4;
          state_d    = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q        <= S_IDLE;
      kind_q         <= K_ILL;
      mstatus_mie_q  <= 1'b0;
      mstatus_mpie_q <= 1'b0;
      mie_meie_q     <= 1'b0;
      mip_meip_q     <= 1'b0;
      mtvec_q        <= {MTVEC_RESET[31:2], 2'b00};
      mscratch_q     <= '0;
      mepc_q         <= '0;
      mcause_q       <= '0;
      pc_q           <= '0;
      csr_addr_q     <= '0;
      csr_we_q       <= 1'b0;
      csr_wval_q     <= '0;
      rd_we_q        <= 1'b0;
      rd_addr_q      <= '0;
      rd_data_q      <= '0;
      redir_q        <= 1'b0;
      redir_pc_q     <= '0;
    end else begin
      state_q        <= state_d;
      kind_q         <= kind_d;
      mstatus_mie_q  <= mstatus_mie_d;
      mstatus_mpie_q <= mstatus_mpie_d;
      mie_meie_q     <= mie_meie_d;
      mip_meip_q     <= IRQ_EXT;
      mtvec_q        <= mtvec_d;
      mscratch_q     <= mscratch_d;
      mepc_q         <= mepc_d;
      mcause_q       <= mcause_d;
      pc_q           <= pc_d;
      csr_addr_q     <= csr_addr_d;
      csr_we_q       <= csr_we_d;
      csr_wval_q     <= csr_wval_d;
      rd_we_q        <= rd_we_d;
      rd_addr_q      <= rd_addr_d;
      rd_data_q      <= rd_data_d;
      redir_q        <= redir_d;
      redir_pc_q     <= redir_pc_d;
    end
  end

  assign O_RD_WE       = rd_we_q;
  assign O_RD_ADDR     = rd_addr_q;
  assign O_RD_DATA     = rd_data_q;
  assign O_REDIRECT    = redir_q;
  assign O_REDIRECT_PC = redir_pc_q;
  assign O_BUSY        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sys_ctrl.sv
// Testbench for sys_ctrl: directed scenarios followed by randomized CSR traffic,
// checked against a CSR-file model held as address-indexed arrays with write masks.
module tb_sys_ctrl;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        I_VALID = 1'b0;
  logic        I_READY;
  logic [31:0] I_INSTR = '0;
  logic [31:0] I_PC = '0;
  logic [31:0] I_RS1_DATA = '0;
  logic        IRQ_EXT = 1'b0;
  logic        O_RD_WE;
  logic [4:0]  O_RD_ADDR;
  logic [31:0] O_RD_DATA;
  logic        O_REDIRECT;
  logic [31:0] O_REDIRECT_PC;
  logic        O_BUSY;

  always #5 CLK = ~CLK;

  sys_ctrl #(.MTVEC_RESET(32'h0000_0100)) dut (
    .CLK(CLK), .RSTn(RSTn), .I_VALID(I_VALID), .I_READY(I_READY),
    .I_INSTR(I_INSTR), .I_PC(I_PC), .I_RS1_DATA(I_RS1_DATA), .IRQ_EXT(IRQ_EXT),
    .O_RD_WE(O_RD_WE), .O_RD_ADDR(O_RD_ADDR), .O_RD_DATA(O_RD_DATA),
    .O_REDIRECT(O_REDIRECT), .O_REDIRECT_PC(O_REDIRECT_PC), .O_BUSY(O_BUSY)
  );

  int checks = 0;
  int errors = 0;

  // Reference CSR file: stored value and writable-bit mask per address.
  logic [31:0] csr_m [int];
  logic [31:0] wmask [int];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    csr_m['h300] = 32'h0;          wmask['h300] = 32'h0000_0088;
    csr_m['h304] = 32'h0;          wmask['h304] = 32'h0000_0800;
    csr_m['h305] = 32'h0000_0100;  wmask['h305] = 32'hFFFF_FFFC;
    csr_m['h340] = 32'h0;          wmask['h340] = 32'hFFFF_FFFF;
    csr_m['h341] = 32'h0;          wmask['h341] = 32'hFFFF_FFFC;
    csr_m['h342] = 32'h0;          wmask['h342] = 32'hFFFF_FFFF;
    csr_m['h344] = 32'h0;          wmask['h344] = 32'h0;
  endtask

  function automatic logic [31:0] rd_m(input int a);
    if (a == 'h300) return csr_m[a] | 32'h0000_1800;
    if (a == 'h344) return IRQ_EXT ? 32'h0000_0800 : 32'h0;
    return csr_m[a];
  endfunction

  task automatic m_trap(input logic [31:0] pc, input logic [31:0] cause);
    logic [31:0] st;
    st = csr_m['h300];
    csr_m['h341] = pc & 32'hFFFF_FFFC;
    csr_m['h342] = cause;
    csr_m['h300] = st[3] ? 32'h80 : 32'h0;
  endtask

  function automatic logic [31:0] enc(input logic [11:0] c, input logic [4:0] r1,
                                      input logic [2:0] f, input logic [4:0] rd);
    return {c, r1, f, rd, 7'h73};
  endfunction

  // Issue one instruction, predict its effect, and check EXEC / TRAP / return-to-idle.
  task automatic run_instr(input string tag, input logic [31:0] ins,
                           input logic [31:0] pc, input logic [31:0] rs1v);
    logic        e_we, e_trap, e_mret, e_wfi, wr;
    logic [4:0]  e_rd;
    logic [31:0] e_data, e_tpc, e_mpc, src, old, nv, st;
    int          a, f3, rs1f;
    e_we = 1'b0; e_trap = 1'b0; e_mret = 1'b0; e_wfi = 1'b0;
    e_rd = ins[11:7]; e_data = '0; e_tpc = '0; e_mpc = '0;
    a = int'(ins[31:20]); f3 = int'(ins[14:12]); rs1f = int'(ins[19:15]);
    if (ins == 32'h0000_0073) begin
      e_trap = 1'b1; e_tpc = csr_m['h305]; m_trap(pc, 32'd11);
    end else if (ins == 32'h0010_0073) begin
      e_trap = 1'b1; e_tpc = csr_m['h305]; m_trap(pc, 32'd3);
    end else if (ins == 32'h3020_0073) begin
      e_mret = 1'b1; e_mpc = csr_m['h341];
      st = csr_m['h300];
      csr_m['h300] = (st[7] ? 32'h8 : 32'h0) | 32'h80;
    end else if (ins == 32'h1050_0073) begin
      e_wfi = 1'b1;
    end else begin
      wr = (f3 % 4 == 1) || (rs1f != 0);
      if (ins[6:0] != 7'h73 || f3 % 4 == 0 || !csr_m.exists(a) || (a == 'h344 && wr)) begin
        e_trap = 1'b1; e_tpc = csr_m['h305]; m_trap(pc, 32'd2);
      end else begin
        src = (f3 >= 4) ? 32'(rs1f) : rs1v;
        old = rd_m(a);
        case (f3 % 4)
          1:       nv = src;
          2:       nv = old | src;
          default: nv = old & ~src;
        endcase
        if (wr) csr_m[a] = nv & wmask[a];
        e_we = (e_rd != 5'd0);
        e_data = old;
      end
    end

    @(negedge CLK);
    I_VALID = 1'b1; I_INSTR = ins; I_PC = pc; I_RS1_DATA = rs1v;
    #1;
    chk({tag, "_ready"}, 32'(I_READY), 32'd1);
    @(negedge CLK);
    I_VALID = 1'b0; I_INSTR = $urandom; I_RS1_DATA = $urandom;
    #1;
    chk({tag, "_exec_busy"}, 32'(O_BUSY), 32'd1);
    chk({tag, "_rd_we"}, 32'(O_RD_WE), 32'(e_we));
    if (e_we) begin
      chk({tag, "_rd_addr"}, 32'(O_RD_ADDR), 32'(e_rd));
      chk({tag, "_rd_data"}, O_RD_DATA, e_data);
    end
    chk({tag, "_exec_redir"}, 32'(O_REDIRECT), 32'(e_mret));
    if (e_mret) chk({tag, "_mret_pc"}, O_REDIRECT_PC, e_mpc);
    if (e_wfi) return;
    if (e_trap) begin
      @(negedge CLK); #1;
      chk({tag, "_trap_redir"}, 32'(O_REDIRECT), 32'd1);
      chk({tag, "_trap_pc"}, O_REDIRECT_PC, e_tpc);
      chk({tag, "_trap_busy"}, 32'(O_BUSY), 32'd1);
      chk({tag, "_trap_we"}, 32'(O_RD_WE), 32'd0);
    end
    @(negedge CLK); #1;
    chk({tag, "_idle_busy"}, 32'(O_BUSY), 32'd0);
    chk({tag, "_idle_redir"}, 32'(O_REDIRECT), 32'd0);
    chk({tag, "_idle_we"}, 32'(O_RD_WE), 32'd0);
  endtask

  initial begin : main
    logic [11:0] ca;
    logic [4:0]  r1, rd;
    logic [2:0]  f3;
    int          sel;
    logic [31:0] e_tpc;

    model_reset();
    repeat (3) @(negedge CLK);
    #1;
    chk("rst_busy", 32'(O_BUSY), 32'd0);
    chk("rst_rd_we", 32'(O_RD_WE), 32'd0);
    chk("rst_rd_addr", 32'(O_RD_ADDR), 32'd0);
    chk("rst_rd_data", O_RD_DATA, 32'd0);
    chk("rst_redir", 32'(O_REDIRECT), 32'd0);
    chk("rst_redir_pc", O_REDIRECT_PC, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    // mtvec reset value, read-only access
    run_instr("rd_mtvec", enc(12'h305, 5'd0, 3'd2, 5'd5), 32'h1000, 32'h0);
    run_instr("rd_mtvec2", enc(12'h305, 5'd0, 3'd2, 5'd5), 32'h1004, 32'h0);
    // mscratch write then clear
    run_instr("w_mscr", enc(12'h340, 5'd1, 3'd1, 5'd0), 32'h1008, 32'hDEAD_BEEF);
    run_instr("c_mscr", enc(12'h340, 5'd1, 3'd3, 5'd6), 32'h100C, 32'h0000_FFFF);
    run_instr("rd_mscr", enc(12'h340, 5'd0, 3'd2, 5'd7), 32'h1010, 32'h0);
    // mtvec=0x400, MIE=1, then ECALL
    run_instr("w_mtvec", enc(12'h305, 5'd1, 3'd1, 5'd0), 32'h1014, 32'h0000_0400);
    run_instr("si_mstat", enc(12'h300, 5'd8, 3'd6, 5'd9), 32'h1018, 32'h0);
    run_instr("ecall", 32'h0000_0073, 32'h2000, 32'h0);
    run_instr("rd_mepc", enc(12'h341, 5'd0, 3'd2, 5'd10), 32'h2100, 32'h0);
    run_instr("rd_mcause", enc(12'h342, 5'd0, 3'd2, 5'd11), 32'h2104, 32'h0);
    run_instr("rd_mstat1", enc(12'h300, 5'd0, 3'd2, 5'd12), 32'h2108, 32'h0);
    run_instr("mret", 32'h3020_0073, 32'h2004, 32'h0);
    run_instr("rd_mstat2", enc(12'h300, 5'd0, 3'd2, 5'd12), 32'h2008, 32'h0);
    // enable MEIE (upper/lower bits must be masked off)
    run_instr("s_mie", enc(12'h304, 5'd1, 3'd2, 5'd13), 32'h200C, 32'hFFFF_FFFF);
    run_instr("rd_mie", enc(12'h304, 5'd0, 3'd2, 5'd13), 32'h2010, 32'h0);

    // External interrupt wins over a valid instruction
    @(negedge CLK);
    IRQ_EXT = 1'b1; I_VALID = 1'b1; I_PC = 32'h3000;
    I_INSTR = enc(12'h340, 5'd0, 3'd2, 5'd14);
    e_tpc = csr_m['h305];
    m_trap(32'h3000, 32'h8000_000B);
    #1;
    chk("irq_ready", 32'(I_READY), 32'd0);
    @(negedge CLK);
    I_VALID = 1'b0; IRQ_EXT = 1'b0;
    #1;
    chk("irq_redir", 32'(O_REDIRECT), 32'd1);
    chk("irq_redir_pc", O_REDIRECT_PC, e_tpc);
    chk("irq_busy", 32'(O_BUSY), 32'd1);
    chk("irq_rd_we", 32'(O_RD_WE), 32'd0);
    @(negedge CLK); #1;
    chk("irq_idle", 32'(O_BUSY), 32'd0);
    run_instr("irq_mcause", enc(12'h342, 5'd0, 3'd2, 5'd15), 32'h3100, 32'h0);
    run_instr("irq_mepc", enc(12'h341, 5'd0, 3'd2, 5'd15), 32'h3104, 32'h0);
    run_instr("irq_mstat", enc(12'h300, 5'd0, 3'd2, 5'd15), 32'h3108, 32'h0);

    // Illegal instructions
    run_instr("ill_mip", enc(12'h344, 5'd1, 3'd1, 5'd7), 32'h4000, 32'h0000_0800);
    run_instr("ill_7c0", enc(12'h7C0, 5'd1, 3'd1, 5'd7), 32'h4004, 32'h1234_5678);
    run_instr("ill_f3_4", enc(12'h340, 5'd1, 3'd4, 5'd7), 32'h4008, 32'h0);
    run_instr("rd_mip", enc(12'h344, 5'd0, 3'd2, 5'd8), 32'h400C, 32'h0);
    // New mtvec (low bits masked) is the next trap target
    run_instr("w_mtvec2", enc(12'h305, 5'd1, 3'd1, 5'd0), 32'h4010, 32'h0000_0803);
    run_instr("ebreak", 32'h0010_0073, 32'h6000, 32'h0);
    run_instr("eb_mcause", enc(12'h342, 5'd0, 3'd2, 5'd3), 32'h6004, 32'h0);

    // WFI with MEIE=1, MIE=0
    run_instr("wfi", 32'h1050_0073, 32'h5000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK); #1;
      chk("wfi_busy", 32'(O_BUSY), 32'd1);
      chk("wfi_noredir", 32'(O_REDIRECT), 32'd0);
    end
    IRQ_EXT = 1'b1;
    @(negedge CLK); #1;
    chk("wfi_redir", 32'(O_REDIRECT), 32'd1);
    chk("wfi_redir_pc", O_REDIRECT_PC, 32'h5004);
    chk("wfi_idle", 32'(O_BUSY), 32'd0);
    IRQ_EXT = 1'b0;
    repeat (2) @(negedge CLK);

    // Randomized CSR traffic (interrupt line held low)
    for (int i = 0; i < 60; i++) begin
      sel = $urandom_range(0, 8);
      case (sel)
        0: ca = 12'h300;
        1: ca = 12'h304;
        2: ca = 12'h305;
        3: ca = 12'h340;
        4: ca = 12'h341;
        5: ca = 12'h342;
        6: ca = 12'h344;
        7: ca = 12'h7C0;
        default: ca = 12'($urandom);
      endcase
      f3 = 3'($urandom_range(1, 7));
      r1 = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
      rd = 5'($urandom);
      run_instr("rand", enc(ca, r1, f3, rd), $urandom & 32'hFFFF_FFFC, $urandom);
    end

    // Reset during EXEC of an ECALL: no redirect, no write, state restored
    @(negedge CLK);
    I_VALID = 1'b1; I_INSTR = 32'h0000_0073; I_PC = 32'h7000;
    @(negedge CLK);
    I_VALID = 1'b0;
    #2 RSTn = 1'b0;
    #1;
    chk("abort_busy", 32'(O_BUSY), 32'd0);
    chk("abort_redir", 32'(O_REDIRECT), 32'd0);
    chk("abort_we", 32'(O_RD_WE), 32'd0);
    @(negedge CLK); #1;
    chk("abort_hold_redir", 32'(O_REDIRECT), 32'd0);
    RSTn = 1'b1;
    model_reset();
    run_instr("post_mtvec", enc(12'h305, 5'd0, 3'd2, 5'd5), 32'h8000, 32'h0);
    run_instr("post_mscr", enc(12'h340, 5'd0, 3'd2, 5'd5), 32'h8004, 32'h0);
    run_instr("post_mstat", enc(12'h300, 5'd0, 3'd2, 5'd5), 32'h8008, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
